// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: digit-serial adder sequencer.
// One CHUNK-wide ripple slice (half-adder pairs) is iterated over the operand
// words, one slice per clock, with the slice carry held in a register between
// iterations. A start/busy/done handshake frames each addition.
module serial_add_ctrl #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N     = WIDTH / CHUNK;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [IDX_W-1:0] idx;
  logic             carry;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  int               base;

  logic [CHUNK-1:0] a_sl;
  logic [CHUNK-1:0] b_sl;
  logic [CHUNK-1:0] sl_sum;
  logic             sl_cy;
  logic             sl_msb_cin;
  logic             c_rip;
  logic             hs;
  logic             hc;

  // Bit offset of the slice being worked on this cycle.
  assign base = int'(idx) * CHUNK;
  assign a_sl = a_r[base +: CHUNK];
  assign b_sl = b_r[base +: CHUNK];

  assign busy = (state != ST_IDLE);
  assign done = (state == ST_DONE);

  // Ripple slice: per bit, a half adder on a/b, then a half adder folding in
  // the incoming carry; the two half-adder carries are ORed. The carry into
  // the top bit is kept so the last slice can form signed overflow.
  always_comb begin
    c_rip      = carry;
    sl_sum     = '0;
    sl_msb_cin = carry;
    hs         = 1'b0;
    hc         = 1'b0;
    for (int i = 0; i < CHUNK; i++) begin
      hs        = a_sl[i] ^ b_sl[i];
      hc        = a_sl[i] & b_sl[i];
      sl_sum[i] = hs ^ c_rip;
      if (i == CHUNK - 1) sl_msb_cin = c_rip;
      c_rip     = hc | (hs & c_rip);
    end
    sl_cy = c_rip;
  end

  // Operand capture on acceptance; pure data, so no reset is needed.
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && start) begin
      a_r <= a;
      b_r <= b;
    end
  end

  // Sequencer: accept in IDLE, one slice per cycle in RUN, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      idx      <= '0;
      carry    <= 1'b0;
      sum      <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            carry    <= c_in;
            idx      <= '0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
            state    <= ST_RUN;
          end
        end
        ST_RUN: begin
          sum[base +: CHUNK] <= sl_sum;
          carry              <= sl_cy;
          if (idx == LAST_IDX) begin
            c_out    <= sl_cy;
            overflow <= sl_msb_cin ^ sl_cy;
            state    <= ST_DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl: three instances (CHUNK = 8, 1, 64) share
// operands and reset; each has its own start. Directed table, hand-written
// handshake/reset sequences, and randomized back-to-back traffic checked
// against a plain 65-bit arithmetic model and an issue-period timing model.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] a;
  logic [63:0] b;
  logic        c_in;
  logic [2:0]  start_v;
  logic [2:0]  busy_v;
  logic [2:0]  done_v;
  logic [2:0]  cout_v;
  logic [2:0]  ovf_v;
  logic [63:0] sum_v [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(64), .CHUNK(8)) u_c8 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a), .b(b), .c_in(c_in),
    .busy(busy_v[0]), .done(done_v[0]), .sum(sum_v[0]), .c_out(cout_v[0]), .overflow(ovf_v[0]));

  serial_add_ctrl #(.WIDTH(64), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a), .b(b), .c_in(c_in),
    .busy(busy_v[1]), .done(done_v[1]), .sum(sum_v[1]), .c_out(cout_v[1]), .overflow(ovf_v[1]));

  serial_add_ctrl #(.WIDTH(64), .CHUNK(64)) u_c64 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a), .b(b), .c_in(c_in),
    .busy(busy_v[2]), .done(done_v[2]), .sum(sum_v[2]), .c_out(cout_v[2]), .overflow(ovf_v[2]));

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic [63:0] s;
    logic        co;
    logic        ov;
  } vec_t;

  typedef struct {
    logic [63:0] s;
    logic        co;
    logic        ov;
  } res_t;

  vec_t vecs [6];

  function automatic int nsl(input int k);
    return (k == 0) ? 8 : ((k == 1) ? 64 : 1);
  endfunction

  // Reference: plain 65-bit addition; signed overflow from operand/result signs.
  function automatic res_t model(input logic [63:0] x, input logic [63:0] y, input logic ci);
    res_t r;
    logic [64:0] t;
    t    = {1'b0, x} + {1'b0, y} + {64'd0, ci};
    r.s  = t[63:0];
    r.co = t[64];
    r.ov = (x[63] == y[63]) && (t[63] != x[63]);
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Pulse start for one cycle, scramble operands after acceptance, then wait
  // (bounded) for done. lat counts cycles from acceptance to done.
  task automatic do_op(input int k, input logic [63:0] ia, input logic [63:0] ib,
                       input logic icin, output int lat);
    a = ia; b = ib; c_in = icin; start_v[k] = 1'b1;
    cyc();
    start_v[k] = 1'b0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; c_in = ~icin;
    chk($sformatf("busy_after_accept_%0d", k), {63'd0, busy_v[k]}, 64'd1);
    lat = 0;
    while (done_v[k] !== 1'b1 && lat < 200) begin
      cyc();
      lat++;
    end
  endtask

  // start held high with fresh random operands every cycle: the timing model
  // predicts acceptance every N+2 cycles and done N cycles after each.
  task automatic run_b2b(input int k, input int nops);
    int   n;
    int   p;
    int   ph;
    res_t q[$];
    res_t e;
    n = nsl(k);
    p = n + 2;
    for (int c = 0; c < nops * p; c++) begin
      a    = {$urandom, $urandom};
      b    = ($urandom_range(0, 3) == 0) ? ~a : {$urandom, $urandom};
      c_in = 1'($urandom_range(0, 1));
      start_v[k] = 1'b1;
      ph = c % p;
      if (ph == 0) q.push_back(model(a, b, c_in));
      cyc();
      chk($sformatf("b2b_done_%0d", k), {63'd0, done_v[k]}, {63'd0, (ph == n)});
      chk($sformatf("b2b_busy_%0d", k), {63'd0, busy_v[k]}, {63'd0, (ph != p - 1)});
      if (ph == n && q.size() > 0) begin
        e = q.pop_front();
        chk($sformatf("b2b_sum_%0d", k), sum_v[k], e.s);
        chk($sformatf("b2b_cout_%0d", k), {63'd0, cout_v[k]}, {63'd0, e.co});
        chk($sformatf("b2b_ovf_%0d", k), {63'd0, ovf_v[k]}, {63'd0, e.ov});
      end
    end
    start_v[k] = 1'b0;
    repeat (2) cyc();
  endtask

  initial begin
    int          lat;
    int          ndone;
    int          done_at;
    logic [63:0] got_sum;
    logic        busy_d;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h0, 1'b1, 1'b0};
    vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    vecs[2] = '{64'h0123_4567_89AB_CDEF, 64'hFEDC_BA98_7654_3210, 1'b1, 64'h0, 1'b1, 1'b0};
    vecs[3] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 64'h0, 1'b1, 1'b1};
    vecs[4] = '{64'h0, 64'h0, 1'b1, 64'h1, 1'b0, 1'b0};
    vecs[5] = '{64'h5, 64'h7, 1'b0, 64'hC, 1'b0, 1'b0};

    rst = 1'b1; start_v = 3'b000; a = 64'd0; b = 64'd0; c_in = 1'b0;
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_busy_%0d", k), {63'd0, busy_v[k]}, 64'd0);
      chk($sformatf("rst_done_%0d", k), {63'd0, done_v[k]}, 64'd0);
      chk($sformatf("rst_sum_%0d", k), sum_v[k], 64'd0);
      chk($sformatf("rst_cout_%0d", k), {63'd0, cout_v[k]}, 64'd0);
      chk($sformatf("rst_ovf_%0d", k), {63'd0, ovf_v[k]}, 64'd0);
    end
    rst = 1'b0;
    cyc();

    // Directed table on every slice width.
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 6; i++) begin
        do_op(k, vecs[i].a, vecs[i].b, vecs[i].cin, lat);
        chk($sformatf("tbl_lat_%0d_%0d", k, i), 64'(lat), 64'(nsl(k)));
        chk($sformatf("tbl_sum_%0d_%0d", k, i), sum_v[k], vecs[i].s);
        chk($sformatf("tbl_cout_%0d_%0d", k, i), {63'd0, cout_v[k]}, {63'd0, vecs[i].co});
        chk($sformatf("tbl_ovf_%0d_%0d", k, i), {63'd0, ovf_v[k]}, {63'd0, vecs[i].ov});
        cyc();
        chk($sformatf("tbl_done_drop_%0d_%0d", k, i), {63'd0, done_v[k]}, 64'd0);
        chk($sformatf("tbl_idle_%0d_%0d", k, i), {63'd0, busy_v[k]}, 64'd0);
        repeat (2) cyc();
        chk($sformatf("tbl_hold_%0d_%0d", k, i), sum_v[k], vecs[i].s);
      end
    end

    // start while busy is ignored and not queued.
    a = 64'h5; b = 64'h7; c_in = 1'b0; start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    ndone = 0; done_at = -1; got_sum = '0; busy_d = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i == 3) begin a = 64'h100; b = 64'h200; start_v[0] = 1'b1; end
      if (i == 4) start_v[0] = 1'b0;
      cyc();
      if (done_v[0] === 1'b1) begin
        ndone++; done_at = i; got_sum = sum_v[0]; busy_d = busy_v[0];
      end
    end
    chk("busy_start_ndone", 64'(ndone), 64'd1);
    chk("busy_start_when", 64'(done_at), 64'd8);
    chk("busy_start_sum", got_sum, 64'hC);
    chk("busy_start_busy_in_done", {63'd0, busy_d}, 64'd1);
    chk("busy_start_not_queued", {63'd0, busy_v[0]}, 64'd0);

    // Reset in the middle of an operation.
    a = 64'hFF; b = 64'h1; c_in = 1'b0; start_v[0] = 1'b1;
    cyc();
    start_v[0] = 1'b0;
    repeat (3) cyc();
    rst = 1'b1;
    cyc();
    chk("midrst_busy", {63'd0, busy_v[0]}, 64'd0);
    chk("midrst_done", {63'd0, done_v[0]}, 64'd0);
    chk("midrst_sum", sum_v[0], 64'd0);
    rst = 1'b0;
    cyc();
    do_op(0, 64'd2, 64'd3, 1'b0, lat);
    chk("midrst_fresh_lat", 64'(lat), 64'd8);
    chk("midrst_fresh_sum", sum_v[0], 64'd5);
    repeat (2) cyc();

    run_b2b(0, 1000);
    run_b2b(2, 1000);
    run_b2b(1, 300);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
